// File: rtl/restoring_div_8by4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : restoring_div_8by4                                         |
// | Description : Sequential restoring divider, NW-bit dividend by DW-bit    |
// |               divisor, one quotient bit per clock, valid/ready on both   |
// |               sides. A zero divisor yields quotient all-ones, remainder  |
// |               = dividend low bits and div_by_zero set.                   |
// |               Optional macro DIV_BACK2BACK_EN: accept new operands in    |
// |               the same cycle as the result handshake (skips IDLE).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module restoring_div_8by4 #(
  parameter int NW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int            CW     = $clog2(NW) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(NW - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;

  // Dividend shift register; quotient bits enter at the LSB as dividend
  // bits leave at the MSB, so it ends up holding the quotient.
  logic [NW-1:0] r_dsr;
  logic [DW-1:0] r_dvs;
  logic [DW-1:0] r_prem;
  logic [CW-1:0] r_cnt;
  logic          r_dbz;

  // Trial value is DW+1 bits wide; the restored or subtracted result is
  // always below the divisor, so only DW bits need to be kept.
  logic [DW:0]   w_t;
  logic          w_ge;
  logic [DW-1:0] w_rem_nxt;

  assign w_t       = {r_prem, r_dsr[NW-1]};
  assign w_ge      = (w_t >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_t[DW-1:0] - r_dvs) : w_t[DW-1:0];

  assign w_accept  = in_valid && w_in_ready;

  // State register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = (divisor != '0) ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        if (r_cnt == C_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
`ifdef DIV_BACK2BACK_EN
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_state_nxt = (divisor != '0) ? S_CALC : S_DONE;
          end else begin
            w_state_nxt = S_IDLE;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dsr  <= '0;
      r_dvs  <= '0;
      r_prem <= '0;
      r_cnt  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_dvs <= divisor;
      r_cnt <= '0;
      if (divisor == '0) begin
        // Zero divisor: result is final immediately, no iterations run.
        r_dsr  <= '1;
        r_prem <= dividend[DW-1:0];
        r_dbz  <= 1'b1;
      end else begin
        r_dsr  <= dividend;
        r_prem <= '0;
        r_dbz  <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_dsr  <= {r_dsr[NW-2:0], w_ge};
      r_prem <= w_rem_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign quotient    = r_dsr;
  assign remainder   = r_prem;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_restoring_div_8by4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_restoring_div_8by4                                      |
// | Description : Scoreboard bench for restoring_div_8by4: directed and      |
// |               random divisions checked against plain / and % arithmetic. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_restoring_div_8by4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  restoring_div_8by4 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         acc;  // cycle stamp taken in the accept cycle
    int         lat;  // edges from that stamp to the first out_valid cycle
  } exp_t;

  exp_t sb[$];
  bit   mon_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ordinary unsigned division; zero divisor gives all-ones
  // quotient and the dividend's low nibble as remainder.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t       e;
    logic [7:0] rr;
    if (b == 4'd0) begin
      e.q   = 8'hFF;
      e.r   = a[3:0];
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = a / b;
      rr    = a % b;
      e.r   = rr[3:0];
      e.dbz = 1'b0;
      e.lat = 9;  // accept edge plus 8 iteration edges
    end
    e.acc = 0;
    return e;
  endfunction

  // Monitor: samples just after the falling edge, when this cycle's inputs
  // are settled exactly as the DUT will see them at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!mon_seen) begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            mon_seen = 1'b1;
          end
          chk("quotient", quotient, sb[0].q);
          chk("remainder", remainder, sb[0].r);
          chk("div_by_zero", div_by_zero, sb[0].dbz);
          if (!out_ready) begin
            chk("in_ready_during_stall", in_ready, 0);
          end else begin
            void'(sb.pop_front());
            mon_seen = 1'b0;
          end
        end
      end
    end
  end

  // Present operands from a falling edge, wait (bounded) for in_ready,
  // push the expectation, and drop in_valid after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b, output int acc);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      acc = cyc;
    end else begin
      e     = model(a, b);
      e.acc = cyc;
      acc   = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 0, 1);
      sb.delete();
      mon_seen = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  // One division, optionally holding out_ready low for 'stall' extra cycles.
  task automatic run_one(input logic [7:0] a, input logic [3:0] b, input int stall);
    int acc;
    out_ready = (stall == 0);
    issue(a, b, acc);
    if (stall > 0) begin
      wait_valid();
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
    end
    wait_empty();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int a1;
    int a2;
    int exp_gap;
    rst       = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_one(8'd200, 4'd7, 0);
    run_one(8'd255, 4'd15, 0);
    run_one(8'd255, 4'd1, 0);
    run_one(8'd5, 4'd9, 0);
    run_one(8'd13, 4'd0, 0);
    run_one(8'd100, 4'd10, 0);
    run_one(8'd0, 4'd3, 0);

    // Backpressure with an ignored operand pulse during CALC.
    out_ready = 1'b0;
    issue(8'd200, 4'd7, a1);
    in_valid = 1'b1;
    dividend = 8'd9;
    divisor  = 4'd3;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_valid();
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    wait_empty();
    run_one(8'd9, 4'd3, 0);

    // Reset in the middle of CALC (fourth iteration).
    out_ready = 1'b1;
    issue(8'd100, 4'd3, a1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    sb.delete();
    mon_seen = 1'b0;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    run_one(8'd77, 4'd6, 0);

    // Two divisions issued as fast as the block will take them.
    out_ready = 1'b1;
    issue(8'd50, 4'd5, a1);
    issue(8'd180, 4'd11, a2);
`ifdef DIV_BACK2BACK_EN
    exp_gap = 9;
`else
    exp_gap = 10;
`endif
    chk("accept_spacing", a2 - a1, exp_gap);
    wait_empty();

    // Random operands and random output stalls.
    for (int i = 0; i < 40; i++) begin
      run_one(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
